div_requester: RTL and testbench
================================

Name: div_requester

Overview:
- Initiator-side sequencer for the floating-point division wrapper used by the conjugate-gradient datapath, e.g. for alpha = r'r / p'Ap.
- Accepts a numerator/denominator pair from CG control over a valid/ready handshake.
- Drives the divider's level-held start, waits for its finish flag, and captures the quotient.
- Returns the quotient over a valid/ready response channel, then releases start so the divider rearms.
- Handles divide-by-zero locally and guards against a hung divider with a timeout.

Parameters:
TIMEOUT, 255, max cycles in WAIT without div_finish before aborting (1..65535).
TW, 16, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  requester can accept a request
num_in  in  32  IEEE-754 single numerator
den_in  in  32  IEEE-754 single denominator
resp_valid  out  1  quotient valid; held until accepted
resp_ready  in  1  consumer accepts the response
quotient  out  32  IEEE-754 single result
div_by_zero  out  1  response came from the zero-denominator path
timeout_err  out  1  response came from the timeout path
div_start  out  1  level start to divider (registered)
div_A  out  32  registered numerator to divider
div_B  out  32  registered denominator to divider
div_result  in  32  divider quotient
div_finish  in  1  divider finish flag

Behaviour:
- Reset values (asynchronous): state=IDLE; req_ready=1; resp_valid=0; div_start=0; quotient=0; div_A=0; div_B=0; div_by_zero=0; timeout_err=0; timeout counter=0.
- Reset mid-operation drops div_start at once. The divider clears its own count and flag on its next start-low edge.
- All outputs are registered.
- States: IDLE, ISSUE_WAIT, RELEASE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch num_in/den_in into div_A/div_B; req_ready goes 0 the next cycle.
  - If den_in[30:0]==0: go to RESP with div_by_zero=1. quotient={num_in[31]^den_in[31], 8'hFF, 23'h0}, or 32'h7FC00000 if num_in[30:0]==0 too. div_start is never raised.
  - Otherwise: div_start=1 and go to ISSUE_WAIT.
- ISSUE_WAIT:
  - div_start stays 1; the counter increments each cycle.
  - On a sampled div_finish==1: capture div_result into quotient, clear both flags, div_start=0, resp_valid=1, go to RELEASE.
  - On counter==TIMEOUT with no finish: quotient=32'h7FC00000, timeout_err=1, div_start=0, resp_valid=1, go to RELEASE.
- Nominal timing with the divider's two-count handshake: accept at edge 0, div_start high in cycle 1, div_finish seen high in cycle 3, resp_valid high in cycle 4. Accept-to-resp_valid latency = 4 cycles.
- RELEASE:
  - div_start=0; stay at least one cycle.
  - Leave only when div_finish is sampled 0 and the response has been accepted; then go to IDLE.
  - The response handshake runs concurrently in this state.
- RESP (zero path only): hold resp_valid; go to IDLE on acceptance.
- Response handshake:
  - Fires on resp_valid&&resp_ready; resp_valid clears the next cycle.
  - quotient and both flags hold until the next response.
  - Flags are mutually exclusive.
- req_ready=1 only in IDLE with resp_valid=0. There is no request overlap and no queueing.
- A stale div_finish=1 seen in IDLE (e.g. after reset) is ignored. An issue is never made while div_finish==1.
- div_A/div_B stay stable from issue until the next accept.

Test Plan:
- Nominal: num=0x40C00000 (6.0), den=0x40000000 (2.0), divider model returns 0x40400000 → resp_valid 4 cycles after accept, quotient=0x40400000, flags 0, div_start high exactly cycles 1–3.
- Backpressure: resp_ready=0 for 10 cycles → resp_valid and quotient stable, req_ready=0 throughout, div_start=0; after accept, req_ready=1 next cycle.
- Zero denominator: num=0xC0800000, den=0x80000000 → quotient=0x7F800000, div_by_zero=1, div_start never asserted. Then num=0, den=0 → quotient=0x7FC00000.
- Timeout with TIMEOUT=8 and div_finish stuck 0 → after 8 WAIT cycles, quotient=0x7FC00000, timeout_err=1, div_start=0; the next request is served normally.
- Back-to-back: two requests with resp_ready=1 → div_start low for at least 1 cycle between them, and the second issue waits until div_finish is seen 0.
- Reset asserted during ISSUE_WAIT → all outputs go to reset values immediately (asynchronously); after release, a new request completes correctly.

Source files
------------

// File: rtl/div_requester.sv
// Initiator-side sequencer for the single-precision divider: takes one num/den pair,
// drives the divider's level start, and returns the quotient (or a zero/timeout result).
module div_requester #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] num_in,
    input  logic [31:0] den_in,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] quotient,
    output logic        div_by_zero,
    output logic        timeout_err,
    output logic        div_start,
    output logic [31:0] div_A,
    output logic [31:0] div_B,
    input  logic [31:0] div_result,
    input  logic        div_finish
);

    localparam logic [31:0] QuietNan = 32'h7FC0_0000;

    typedef enum logic [1:0] {StIdle, StIssueWait, StRelease, StResp} state_e;

    state_e        state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic          div_start_q, div_start_d;
    logic [31:0]   quotient_q, quotient_d;
    logic [31:0]   div_a_q, div_a_d;
    logic [31:0]   div_b_q, div_b_d;
    logic          div_by_zero_q, div_by_zero_d;
    logic          timeout_err_q, timeout_err_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic          accept;
    logic          resp_fire;
    logic          den_zero;
    logic          finished;
    logic [TW-1:0] cnt_inc;
    logic          timed_out;

    assign accept    = req_valid && req_ready_q;
    assign resp_fire = resp_valid_q && resp_ready;
    assign den_zero  = (den_in[30:0] == 31'd0);
    // A finish only counts once our own start has actually been presented.
    assign finished  = div_start_q && div_finish;
    assign cnt_inc   = cnt_q + TW'(1);
    assign timed_out = (cnt_inc == TW'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            div_start_q   <= 1'b0;
            quotient_q    <= 32'd0;
            div_a_q       <= 32'd0;
            div_b_q       <= 32'd0;
            div_by_zero_q <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            div_start_q   <= div_start_d;
            quotient_q    <= quotient_d;
            div_a_q       <= div_a_d;
            div_b_q       <= div_b_d;
            div_by_zero_q <= div_by_zero_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (accept) state_d = den_zero ? StResp : StIssueWait;
            StIssueWait: if (finished || timed_out) state_d = StRelease;
            StRelease:   if (!div_finish && (!resp_valid_q || resp_ready)) state_d = StIdle;
            StResp:      if (resp_fire) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_d   = (state_d == StIdle);
        resp_valid_d  = resp_valid_q && !resp_ready;
        div_start_d   = 1'b0;
        quotient_d    = quotient_q;
        div_a_d       = div_a_q;
        div_b_d       = div_b_q;
        div_by_zero_d = div_by_zero_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (accept) begin
                    div_a_d = num_in;
                    div_b_d = den_in;
                    if (den_zero) begin
                        quotient_d    = (num_in[30:0] == 31'd0) ? QuietNan :
                                        {num_in[31] ^ den_in[31], 8'hFF, 23'd0};
                        div_by_zero_d = 1'b1;
                        timeout_err_d = 1'b0;
                        resp_valid_d  = 1'b1;
                    end else begin
                        // Hold off the start while a stale finish is still up.
                        div_start_d = !div_finish;
                    end
                end
            end
            StIssueWait: begin
                cnt_d       = cnt_inc;
                div_start_d = div_start_q || !div_finish;
                if (finished) begin
                    quotient_d    = div_result;
                    div_by_zero_d = 1'b0;
                    timeout_err_d = 1'b0;
                    div_start_d   = 1'b0;
                    resp_valid_d  = 1'b1;
                end else if (timed_out) begin
                    quotient_d    = QuietNan;
                    div_by_zero_d = 1'b0;
                    timeout_err_d = 1'b1;
                    div_start_d   = 1'b0;
                    resp_valid_d  = 1'b1;
                end
            end
            StRelease, StResp: ;
            default: ;
        endcase
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign div_start   = div_start_q;
    assign quotient    = quotient_q;
    assign div_A       = div_a_q;
    assign div_B       = div_b_q;
    assign div_by_zero = div_by_zero_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_div_requester.sv
// Scoreboard bench for div_requester with a two-count divider model that can be made to hang.
module tb_div_requester;

    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned TW      = 16;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        req_valid  = 1'b0;
    logic        resp_ready = 1'b1;
    logic [31:0] num_in     = 32'd0;
    logic [31:0] den_in     = 32'd0;
    logic        req_ready, resp_valid, div_by_zero, timeout_err, div_start;
    logic [31:0] quotient, div_A, div_B, div_result;

    logic        stuck      = 1'b0;
    logic [31:0] model_res  = 32'd0;
    logic [1:0]  dcnt       = 2'd0;
    logic        div_finish = 1'b0;

    typedef struct packed {
        logic [31:0] q;
        logic        dbz;
        logic        to;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_total     = 0;
    int   n_bad       = 0;
    int   start_rises = 0;
    logic prev_start  = 1'b0;
    logic prev_fin    = 1'b0;

    div_requester #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .num_in      (num_in),
        .den_in      (den_in),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .quotient    (quotient),
        .div_by_zero (div_by_zero),
        .timeout_err (timeout_err),
        .div_start   (div_start),
        .div_A       (div_A),
        .div_B       (div_B),
        .div_result  (div_result),
        .div_finish  (div_finish)
    );

    always #5 clk = ~clk;

    assign div_result = model_res;

    // Divider: finish rises on the second start-high edge, clears on a start-low edge.
    always @(posedge clk) begin
        if (!div_start) begin
            dcnt       <= 2'd0;
            div_finish <= 1'b0;
        end else if (!stuck) begin
            if (dcnt == 2'd1) div_finish <= 1'b1;
            if (dcnt != 2'd3) dcnt <= dcnt + 2'd1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check_val("sb_empty", 32'(sb.size()), 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    check_val("resp_q", quotient, mon_e.q);
                    check_val("resp_dbz", 32'(div_by_zero), 32'(mon_e.dbz));
                    check_val("resp_to", 32'(timeout_err), 32'(mon_e.to));
                end
            end
            if (div_start && !prev_start) begin
                start_rises++;
                check_val("issue_fin", 32'(prev_fin), 32'd0);
            end
        end
        prev_start = div_start;
        prev_fin   = div_finish;
    end

    // Returns #1 after the accepting edge, so the next negedge is cycle 1.
    task automatic issue(input logic [31:0] n, input logic [31:0] d, input logic [31:0] r,
                         input logic [31:0] eq, input logic edbz, input logic eto);
        exp_t e;
        int   k = 0;
        @(negedge clk);
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_val("req_rdy_wait", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        num_in    = n;
        den_in    = d;
        model_res = r;
        e.q = eq; e.dbz = edbz; e.to = eto;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        @(negedge clk);
        while (!(sb.size() == 0 && req_ready) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_val("wait_done", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_rdy"}, 32'(req_ready), 32'd1);
        check_val({tag, "_rv"}, 32'(resp_valid), 32'd0);
        check_val({tag, "_st"}, 32'(div_start), 32'd0);
        check_val({tag, "_q"}, quotient, 32'd0);
        check_val({tag, "_a"}, div_A, 32'd0);
        check_val({tag, "_b"}, div_B, 32'd0);
        check_val({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
        check_val({tag, "_to"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        int snap;
        #12;
        check_reset_vals("rst0");
        @(posedge clk);
        #1 reset = 1'b0;

        // Nominal 6.0 / 2.0
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 32'h4040_0000, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_val($sformatf("nom_start_c%0d", k), 32'(div_start), 32'(k <= 3));
            check_val($sformatf("nom_rv_c%0d", k), 32'(resp_valid), 32'(k == 4));
        end
        check_val("nom_a", div_A, 32'h40C0_0000);
        check_val("nom_b", div_B, 32'h4000_0000);
        wait_done();

        // Backpressure
        resp_ready = 1'b0;
        issue(32'h4120_0000, 32'h40A0_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
        for (int k = 0; k < 20 && !resp_valid; k++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check_val("bp_rv", 32'(resp_valid), 32'd1);
            check_val("bp_q", quotient, 32'h4000_0000);
            check_val("bp_rdy", 32'(req_ready), 32'd0);
            check_val("bp_st", 32'(div_start), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("bp_rdy_after", 32'(req_ready), 32'd1);
        check_val("bp_rv_after", 32'(resp_valid), 32'd0);

        // Zero denominators
        snap = start_rises;
        issue(32'hC080_0000, 32'h8000_0000, 32'h1111_1111, 32'h7F80_0000, 1'b1, 1'b0);
        wait_done();
        issue(32'h0000_0000, 32'h0000_0000, 32'h1111_1111, 32'h7FC0_0000, 1'b1, 1'b0);
        wait_done();
        check_val("dbz_no_start", 32'(start_rises - snap), 32'd0);

        // Hung divider
        stuck = 1'b1;
        issue(32'h3F80_0000, 32'h4000_0000, 32'h2222_2222, 32'h7FC0_0000, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check_val($sformatf("to_start_c%0d", k), 32'(div_start), 32'(k <= 8));
            check_val($sformatf("to_rv_c%0d", k), 32'(resp_valid), 32'(k == 9));
        end
        stuck = 1'b0;
        wait_done();
        issue(32'h4100_0000, 32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
        wait_done();

        // Back-to-back
        snap = start_rises;
        issue(32'h4040_0000, 32'h3F80_0000, 32'h4040_0000, 32'h4040_0000, 1'b0, 1'b0);
        issue(32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
        wait_done();
        check_val("b2b_issues", 32'(start_rises - snap), 32'd2);

        // Reset while waiting on the divider
        stuck = 1'b1;
        issue(32'h4140_0000, 32'h4000_0000, 32'h4333_3333, 32'h4333_3333, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_val("mid_st_pre", 32'(div_start), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        sb.delete();
        stuck = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        issue(32'h4140_0000, 32'h4000_0000, 32'h4040_0000, 32'h4040_0000, 1'b0, 1'b0);
        wait_done();

        check_val("sb_left", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
